// File: rtl/fwd_hazard_unit_pkg.sv
// bexkat1Def: shared reg_write codes, regfile select constant and stage-to-select encoding
package bexkat1Def;
  typedef enum logic [1:0] {
    REG_WR_NONE = 2'd0,
    REG_WR_BYTE = 2'd1,
    REG_WR_HALF = 2'd2,
    REG_WR_WORD = 2'd3
  } reg_write_t;
  localparam int FWD_SEL_REGFILE = 0;
  function automatic int stage_sel(input int k);
    return k + 1;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_scoreboard.sv
// fwd_scoreboard: per-register pending long-op counters; ports issue/done in, cnt/busy/sticky err out
module fwd_scoreboard
  import bexkat1Def::*;
#(
  parameter int REG_W = 4,
  parameter int CNT_W = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              issue_i,
  input  logic [REG_W-1:0]                  issue_dst_i,
  input  logic                              done_i,
  input  logic [REG_W-1:0]                  done_dst_i,
  output logic [2**REG_W-1:0][CNT_W-1:0]    cnt_o,
  output logic [2**REG_W-1:0]               busy_o,
  output logic                              err_o
);
  localparam int NREG = 2**REG_W;
  logic [NREG-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [NREG-1:0]            inc, dec;
  logic                       err_d, err_q;
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = issue_i && issue_dst_i == REG_W'(r);
      // an empty counter is only decremented when a same-cycle issue refills it
      dec[r] = done_i && done_dst_i == REG_W'(r) && (cnt_q[r] != '0 || inc[r]);
      cnt_d[r] = cnt_q[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
      busy_o[r] = |cnt_q[r];
    end
    err_d = err_q | (done_i && cnt_q[done_dst_i] == '0);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: bypass selects (youngest stage wins), load-use/RAW/WAW stall, long-op scoreboard
//   in : clk_i, rst_i (async low), id_* (ID operands/dest), stg_* (bypass stages), lop_done_*
//   out: fwd_sel_o, stall_o, lop_issue_o, sb_busy_o, sb_err_o
//   FWD_STATS_EN adds stat_clr_i, stat_stall_o, stat_fwd_o cycle counters
module fwd_hazard_unit
  import bexkat1Def::*;
#(
  parameter int NSTAGE = 2,
  parameter int NSRC   = 2,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 2,
  localparam int SEL_W = $clog2(NSTAGE + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    id_valid_i,
  input  logic [NSRC*REG_W-1:0]   id_src_i,
  input  logic [NSRC-1:0]         id_src_use_i,
  input  logic [REG_W-1:0]        id_dst_i,
  input  logic                    id_wr_i,
  input  logic                    id_lop_i,
  input  logic [NSTAGE*REG_W-1:0] stg_dst_i,
  input  logic [NSTAGE*2-1:0]     stg_wr_i,
  input  logic [NSTAGE-1:0]       stg_pend_i,
  input  logic                    lop_done_i,
  input  logic [REG_W-1:0]        lop_done_dst_i,
  output logic [NSRC*SEL_W-1:0]   fwd_sel_o,
  output logic                    stall_o,
  output logic                    lop_issue_o,
  output logic [2**REG_W-1:0]     sb_busy_o,
  output logic                    sb_err_o
`ifdef FWD_STATS_EN
  ,
  input  logic                    stat_clr_i,
  output logic [31:0]             stat_stall_o,
  output logic [31:0]             stat_fwd_o
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [2**REG_W-1:0][CNT_W-1:0] cnt;
  logic [NSRC-1:0]                lu;
  logic                           hazard;
  always_comb begin
    fwd_sel_o = {NSRC{SEL_W'(FWD_SEL_REGFILE)}};
    lu = '0;
    hazard = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      // scan oldest to youngest so the youngest match overwrites
      for (int k = NSTAGE - 1; k >= 0; k--)
        if (id_src_use_i[s] && reg_write_t'(stg_wr_i[2*k+:2]) != REG_WR_NONE &&
            stg_dst_i[REG_W*k+:REG_W] == id_src_i[REG_W*s+:REG_W]) begin
          fwd_sel_o[SEL_W*s+:SEL_W] = SEL_W'(stage_sel(k));
          lu[s] = stg_pend_i[k];
        end
      // a last outstanding long op completing this cycle is bypassed, not stalled on
      if (id_src_use_i[s] && cnt[id_src_i[REG_W*s+:REG_W]] != '0 &&
          !(lop_done_i && lop_done_dst_i == id_src_i[REG_W*s+:REG_W] &&
            cnt[id_src_i[REG_W*s+:REG_W]] == CNT_W'(1)))
        hazard = 1'b1;
    end
    hazard = hazard | (|lu) | (id_wr_i && cnt[id_dst_i] != '0) | (id_lop_i && cnt[id_dst_i] == CNT_MAX);
    stall_o = id_valid_i & hazard;
    lop_issue_o = id_valid_i & id_lop_i & ~stall_o;
  end
  fwd_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (lop_issue_o),
    .issue_dst_i(id_dst_i),
    .done_i     (lop_done_i),
    .done_dst_i (lop_done_dst_i),
    .cnt_o      (cnt),
    .busy_o     (sb_busy_o),
    .err_o      (sb_err_o)
  );
`ifdef FWD_STATS_EN
  logic [31:0] stat_stall_d, stat_stall_q, stat_fwd_d, stat_fwd_q;
  always_comb begin
    stat_stall_d = stat_clr_i ? '0 : stat_stall_q + 32'(stall_o);
    stat_fwd_d = stat_clr_i ? '0 : stat_fwd_q + 32'((|fwd_sel_o) & ~stall_o);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      stat_stall_q <= '0;
      stat_fwd_q <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q <= stat_fwd_d;
    end
  assign stat_stall_o = stat_stall_q;
  assign stat_fwd_o = stat_fwd_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors checked against a per-register count model every cycle
module tb_fwd_hazard_unit;
  localparam int NREG = 16;
  localparam int MAXC = 3;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  always #5 clk = ~clk;
  logic        id_valid, id_wr, id_lop, lop_done;
  logic [7:0]  id_src, stg_dst;
  logic [1:0]  id_src_use, stg_pend;
  logic [3:0]  id_dst, stg_wr, lop_done_dst, fwd_sel;
  logic        stall, lop_issue, sb_err;
  logic [15:0] sb_busy;
`ifdef FWD_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_stall, stat_fwd;
`endif
  int total = 0, bad = 0;
  int mcnt[NREG];
  bit merr;

  fwd_hazard_unit dut (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
    .id_src_use_i(id_src_use), .id_dst_i(id_dst), .id_wr_i(id_wr), .id_lop_i(id_lop),
    .stg_dst_i(stg_dst), .stg_wr_i(stg_wr), .stg_pend_i(stg_pend),
    .lop_done_i(lop_done), .lop_done_dst_i(lop_done_dst), .fwd_sel_o(fwd_sel),
    .stall_o(stall), .lop_issue_o(lop_issue), .sb_busy_o(sb_busy), .sb_err_o(sb_err)
`ifdef FWD_STATS_EN
    , .stat_clr_i(stat_clr), .stat_stall_o(stat_stall), .stat_fwd_o(stat_fwd)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int win(input int s);
    for (int k = 0; k < 2; k++)
      if (stg_wr[2*k+:2] != 0 && stg_dst[4*k+:4] == id_src[4*s+:4]) return k;
    return -1;
  endfunction

  function automatic logic [3:0] exp_sel();
    logic [3:0] r = '0;
    for (int s = 0; s < 2; s++)
      if (id_src_use[s] && win(s) >= 0) r[2*s+:2] = 2'(win(s) + 1);
    return r;
  endfunction

  function automatic bit exp_stall();
    if (!id_valid) return 0;
    for (int s = 0; s < 2; s++) begin
      int c, w;
      if (!id_src_use[s]) continue;
      w = win(s);
      if (w >= 0 && stg_pend[w]) return 1;
      c = mcnt[id_src[4*s+:4]];
      if (c > 0 && !(lop_done && lop_done_dst == id_src[4*s+:4] && c == 1)) return 1;
    end
    if (id_wr && mcnt[id_dst] > 0) return 1;
    if (id_lop && mcnt[id_dst] == MAXC) return 1;
    return 0;
  endfunction

  function automatic logic [15:0] exp_busy();
    logic [15:0] b;
    for (int r = 0; r < NREG; r++) b[r] = mcnt[r] > 0;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int nxt[NREG];
    bit iss;
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mcnt[r] <= 0;
      merr <= 1'b0;
    end else begin
      nxt = mcnt;
      iss = id_valid && id_lop && !exp_stall();
      if (iss) nxt[id_dst] = nxt[id_dst] + 1;
      if (lop_done && (mcnt[lop_done_dst] > 0 || (iss && id_dst == lop_done_dst)))
        nxt[lop_done_dst] = nxt[lop_done_dst] - 1;
      mcnt <= nxt;
      if (lop_done && mcnt[lop_done_dst] == 0) merr <= 1'b1;
    end
  end

  always @(negedge clk)
    if (run) begin
      chk("sel", 64'(fwd_sel), 64'(exp_sel()));
      chk("stall", 64'(stall), 64'(exp_stall()));
      chk("issue", 64'(lop_issue), 64'(id_valid && id_lop && !exp_stall()));
      chk("busy", 64'(sb_busy), 64'(exp_busy()));
      chk("err", 64'(sb_err), 64'(merr));
    end

  task automatic idle();
    id_valid = 0; id_src = '0; id_src_use = '0; id_dst = '0; id_wr = 0; id_lop = 0;
    stg_dst = '0; stg_wr = '0; stg_pend = '0; lop_done = 0; lop_done_dst = '0;
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  task automatic lop(input logic [3:0] d);
    idle(); id_valid = 1; id_lop = 1; id_dst = d;
  endtask
  task automatic done(input logic [3:0] d);
    idle(); lop_done = 1; lop_done_dst = d;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_busy", 64'(sb_busy), 64'h0);
    chk("rst_err", 64'(sb_err), 64'h0);
    nxt();
    rst_n = 1; run = 1;
    // youngest of two matching stages wins
    id_valid = 1; stg_dst = {4'd3, 4'd3}; stg_wr = 4'b0101; id_src = {4'd0, 4'd3}; id_src_use = 2'b01;
    mid(); chk("young_sel", 64'(fwd_sel[1:0]), 64'd1); chk("young_stall", 64'(stall), 64'd0); nxt();
    // only the oldest stage matches
    stg_dst = {4'd6, 4'd5}; stg_wr = 4'b1000; id_src = {4'd0, 4'd6};
    mid(); chk("old_sel", 64'(fwd_sel[1:0]), 64'd2); nxt();
    // load-use on source 1
    idle(); id_valid = 1; stg_dst = {4'd0, 4'd5}; stg_wr = 4'b0001; stg_pend = 2'b01;
    id_src = {4'd5, 4'd0}; id_src_use = 2'b10;
    mid(); chk("lu_stall", 64'(stall), 64'd1); nxt();
    stg_pend = 2'b00;
    mid(); chk("lu_sel", 64'(fwd_sel[3:2]), 64'd1); chk("lu_go", 64'(stall), 64'd0); nxt();
    // long op r7 with same-cycle wakeup
    lop(4'd7);
    mid(); chk("r7_issue", 64'(lop_issue), 64'd1); nxt();
    idle(); id_valid = 1; id_src = {4'd0, 4'd7}; id_src_use = 2'b01;
    mid(); chk("r7_busy", 64'(sb_busy[7]), 64'd1); chk("r7_stall0", 64'(stall), 64'd1); nxt();
    mid(); chk("r7_stall1", 64'(stall), 64'd1); nxt();
    lop_done = 1; lop_done_dst = 4'd7;
    mid(); chk("r7_wake", 64'(stall), 64'd0); nxt();
    idle();
    mid(); chk("r7_free", 64'(sb_busy[7]), 64'd0); nxt();
    // saturate r2
    for (int i = 0; i < 3; i++) begin
      lop(4'd2);
      mid(); chk("r2_issue", 64'(lop_issue), 64'd1); nxt();
    end
    mid(); chk("r2_sat_stall", 64'(stall), 64'd1); chk("r2_sat_issue", 64'(lop_issue), 64'd0); nxt();
    idle(); id_valid = 1; id_wr = 1; id_dst = 4'd2;
    mid(); chk("r2_waw", 64'(stall), 64'd1); nxt();
    done(4'd2); nxt();
    lop(4'd2); lop_done = 1; lop_done_dst = 4'd2;
    mid(); chk("r2_both", 64'(lop_issue), 64'd1); nxt();
    lop(4'd2);
    mid(); chk("r2_refill", 64'(lop_issue), 64'd1); nxt();
    mid(); chk("r2_resat", 64'(stall), 64'd1); nxt();
    for (int i = 0; i < 3; i++) begin
      done(4'd2); nxt();
    end
    idle();
    mid(); chk("r2_drained", 64'(sb_busy), 64'h0); chk("r2_noerr", 64'(sb_err), 64'd0); nxt();
    // spurious done, sticky error, async reset
    lop(4'd4); nxt();
    done(4'd9); nxt();
    idle();
    mid(); chk("err_set", 64'(sb_err), 64'd1); nxt();
    nxt();
    mid(); chk("err_sticky", 64'(sb_err), 64'd1); chk("r4_busy", 64'(sb_busy[4]), 64'd1);
    #1 rst_n = 0;
    #1 chk("async_err", 64'(sb_err), 64'd0); chk("async_busy", 64'(sb_busy), 64'h0);
    @(posedge clk); #1 rst_n = 1;
    done(4'd4); nxt();
    idle();
    mid(); chk("late_done_err", 64'(sb_err), 64'd1); nxt();
`ifdef FWD_STATS_EN
    stat_clr = 1; nxt(); stat_clr = 0;
    idle(); id_valid = 1; stg_dst = {4'd0, 4'd5}; stg_wr = 4'b0001; stg_pend = 2'b01;
    id_src = {4'd0, 4'd5}; id_src_use = 2'b01;
    for (int i = 0; i < 5; i++) nxt();
    stg_pend = 2'b00;
    for (int i = 0; i < 3; i++) nxt();
    idle();
    mid(); chk("stat_stall", 64'(stat_stall), 64'd5); chk("stat_fwd", 64'(stat_fwd), 64'd3);
    stat_clr = 1; nxt(); stat_clr = 0;
    mid(); chk("stat_stall_clr", 64'(stat_stall), 64'd0); chk("stat_fwd_clr", 64'(stat_fwd), 64'd0);
`endif
    nxt();
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2-stage forwarder for the bexkat1 pipeline.
- Generates per-operand bypass selects over NSTAGE downstream stages, with youngest-stage priority.
- Detects load-use hazards and drives a stall.
- Contains a sequential scoreboard of pending writes from long-latency units (mul/div, multi-cycle loads). That scoreboard adds RAW and WAW stalls for results that are not available through the bypass network.

Parameters:
- NSTAGE, 2: number of bypass source stages; index 0 is youngest (EXE), NSTAGE-1 is oldest.
- NSRC, 2: number of source operands checked in ID.
- REG_W, 4: register index width; the register file has 2**REG_W entries.
- CNT_W, 2: width of each per-register pending counter; at most 2**CNT_W-1 long ops may be outstanding per register.
- SEL_W, $clog2(NSTAGE+1): width of each select field (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  ID holds a real instruction.
- id_src_i  in  NSRC*REG_W  source register indices.
- id_src_use_i  in  NSRC  per-source "operand is read".
- id_dst_i  in  REG_W  ID destination register.
- id_wr_i  in  1  ID instruction writes a register through the normal pipe.
- id_lop_i  in  1  ID instruction is a long op; it writes id_dst_i later via lop_done.
- stg_dst_i  in  NSTAGE*REG_W  destination register per stage.
- stg_wr_i  in  NSTAGE*2  reg_write code per stage; nonzero means the stage writes.
- stg_pend_i  in  NSTAGE  stage result not yet produced (load in flight).
- lop_done_i  in  1  long-op writeback this cycle.
- lop_done_dst_i  in  REG_W  register written back.
- fwd_sel_o  out  NSRC*SEL_W  per source: 0 = register file, k = stage k-1.
- stall_o  out  1  hold ID / insert bubble.
- lop_issue_o  out  1  long op accepted this cycle.
- sb_busy_o  out  2**REG_W  register has a pending count that is nonzero.
- sb_err_o  out  1  sticky: lop_done arrived for a register whose count was 0.

Behaviour:
- Select logic (combinational):
  - For each source s with id_src_use_i[s]=1, scan stages from 0 upward.
  - The first stage k whose stg_wr_i field is nonzero and whose stg_dst_i equals id_src_i[s] gives fwd_sel_o[s] = k+1.
  - With no match, or id_src_use_i[s]=0, fwd_sel_o[s] = 0.
  - When multiple stages match, the youngest stage always wins.
- Stall (combinational; stall_o = 0 when id_valid_i = 0). stall_o = 1 when any of the following holds:
  - (a) the winning stage for any used source has stg_pend_i = 1 (load-use);
  - (b) any used source has a nonzero pending count, unless lop_done_i for that register occurs this cycle and its count is 1 (same-cycle wakeup);
  - (c) id_wr_i = 1 and the pending count of id_dst_i is nonzero (WAW ordering);
  - (d) id_lop_i = 1 and the count of id_dst_i is 2**CNT_W-1 (saturated).
- lop_issue_o = id_valid_i & id_lop_i & ~stall_o.
- Scoreboard (sequential, one CNT_W counter per register):
  - On issue, cnt[id_dst_i] increments.
  - On lop_done_i, cnt[lop_done_dst_i] decrements.
  - Issue and done to the same register in the same cycle leave the count unchanged.
  - Issue and done to different registers both apply.
  - Done with count 0: the count stays 0 and sb_err_o is set. sb_err_o clears only on reset.
  - Updates are visible in sb_busy_o and stall_o from the next cycle.
- Reset (rst_i low, asynchronous): all counters 0, sb_err_o 0, sb_busy_o all 0. The combinational outputs follow their inputs.
- Reset mid-operation discards all outstanding long ops. Any late lop_done after reset sets sb_err_o.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined, adds outputs stat_stall_o (32-bit) and stat_fwd_o (32-bit).
  - stat_stall_o counts cycles with stall_o = 1.
  - stat_fwd_o counts cycles in which any fwd_sel_o field is nonzero and stall_o = 0.
  - Both counters wrap at 2**32, reset to 0, and are cleared synchronously by input stat_clr_i.
- When not defined, these ports and counters do not exist.

Decomposition:
- Shared package bexkat1Def holds:
  - the reg_write code enum;
  - the FWD_SEL_REGFILE = 0 constant;
  - a helper function returning the stage-to-select encoding.
- One sub-module, fwd_scoreboard, holds the counter array, sb_busy_o and sb_err_o. Its inputs are the issue, done and reset signals.
- Select and stall logic stay in the top level.

Test Plan:
- stg_dst = {r3, r3}, stg_wr = {1, 1}, id_src[0] = r3 → fwd_sel[0] = 1 (youngest wins), stall_o = 0.
- stg0 dst = r5, stg_wr = 1, stg_pend[0] = 1, id_src[1] = r5 used → stall_o = 1. Drop stg_pend → fwd_sel[1] = 1, stall_o = 0.
- Issue a long op to r7, then an ID read of r7 → stall_o = 1 until the lop_done r7 cycle, where stall_o = 0 (same-cycle wakeup). sb_busy[7] is 0 on the following cycle.
- Issue a long op to r2 three times with CNT_W = 2 → count reaches 3. A fourth id_lop to r2 → stall_o = 1, lop_issue_o = 0. Issue and done to r2 in the same cycle → count unchanged.
- lop_done r9 with cnt = 0 → sb_err_o = 1 and stays 1. Assert rst_i low mid-cycle → sb_err_o = 0 and all counts 0 immediately (asynchronous).
- FWD_STATS_EN defined: 5 stall cycles and 3 forwarding cycles → stat_stall_o = 5, stat_fwd_o = 3. stat_clr_i → both 0.
